// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage.
// Holds the PC and requests one word at a time from instruction memory.
// Each accepted word is registered for decode together with its PC+4 and a
// taken/not-taken prediction. The prediction comes from a 2-bit bimodal BHT,
// combined with predecode of the conditional-branch opcode.
// Execute redirects, decode stalls and halt are all resolved here.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          BHT_BITS      = 6,
  parameter logic [5:0]  BRANCH_OPCODE = 6'b000100
) (
  input  logic        iClk,
  input  logic        iRst_n,
  output logic [31:0] oImemAddr,
  output logic        oImemReq,
  input  logic [31:0] iImemData,
  input  logic        iImemValid,
  input  logic        iStall,
  input  logic        iHalt,
  input  logic        iRedirect,
  input  logic [31:0] iRedirectPC,
  input  logic        iBhtUpdate,
  input  logic [31:0] iBhtPC,
  input  logic        iBhtTaken,
  output logic [31:0] oInstruction,
  output logic [31:0] oNextPC,
  output logic        oBranchPredict,
  output logic        oValid
);

  localparam int BHT_ENTRIES = 1 << BHT_BITS;

  typedef enum logic [1:0] {
    REQ    = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetchState;

  fetchState   rState;
  logic [31:0] rPC;
  logic        rSquash;
  logic [31:0] rBufInstr;
  logic [31:0] rBufPC;
  logic [31:0] rInstruction;
  logic [31:0] rNextPC;
  logic        rPredict;
  logic        rValid;

  // The word being accepted comes from memory in REQ and from the stall buffer in HOLD.
  logic [31:0]         selInstr;
  logic [31:0]         selPC;
  logic [BHT_BITS-1:0] predIdx;
  logic [BHT_BITS-1:0] bhtUpdIdx;
  logic [1:0]          bhtCnt [BHT_ENTRIES];
  logic [1:0]          predCnt;
  logic                isBranch;
  logic                predTaken;
  logic [31:0]         fallThrough;
  logic [31:0]         branchTarget;
  logic [31:0]         nextFetchPC;
  logic                deliverNow;
  logic                bufferNow;
  logic                squashNext;
  logic                unusedBhtPcBits;

  assign selInstr     = (rState == HOLD) ? rBufInstr : iImemData;
  assign selPC        = (rState == HOLD) ? rBufPC : rPC;
  assign predIdx      = selPC[BHT_BITS+1:2];
  assign bhtUpdIdx    = iBhtPC[BHT_BITS+1:2];
  assign predCnt      = bhtCnt[predIdx];
  assign isBranch     = (selInstr[31:26] == BRANCH_OPCODE);
  assign predTaken    = isBranch & predCnt[1];
  assign fallThrough  = selPC + 32'd4;
  assign branchTarget = fallThrough + {{9{selInstr[20]}}, selInstr[20:0], 2'b00};
  assign nextFetchPC  = predTaken ? branchTarget : fallThrough;

  // A word reaches decode when decode is free and either the buffer holds one
  // or a live (non-squashed) response arrives this cycle.
  assign deliverNow = !iStall &&
                      ((rState == HOLD) ||
                       ((rState == REQ) && iImemValid && !rSquash));
  assign bufferNow  = iStall && (rState == REQ) && iImemValid && !rSquash;

  // When we abandon the current request before its response arrives, the late
  // response must be dropped. A pending squash also carries over.
  assign squashNext = ((rState == REQ) || rSquash) && !iImemValid;

  // Only the index bits of the resolved-branch PC address the table.
  assign unusedBhtPcBits = ^{iBhtPC[31:BHT_BITS+2], iBhtPC[1:0]};

  // Each BHT entry is a saturating 2-bit counter. Reads are combinational,
  // so a same-cycle update is seen only from the next cycle on.
  genvar gi;
  generate
    for (gi = 0; gi < BHT_ENTRIES; gi++) begin : genBht
      logic [1:0] rCnt;

      // Saturating increment on taken, decrement on not-taken.
      always_ff @(posedge iClk) begin
        if (!iRst_n) begin
          rCnt <= 2'b01;
        end else if (iBhtUpdate && (bhtUpdIdx == BHT_BITS'(gi))) begin
          if (iBhtTaken) begin
            if (rCnt != 2'b11) rCnt <= rCnt + 2'b01;
          end else begin
            if (rCnt != 2'b00) rCnt <= rCnt - 2'b01;
          end
        end
      end

      assign bhtCnt[gi] = rCnt;
    end
  endgenerate

  // Fetch FSM. Priority order is reset, redirect, halt, then normal fetch.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      rState       <= REQ;
      rPC          <= RESET_PC;
      rSquash      <= 1'b0;
      rBufInstr    <= 32'd0;
      rBufPC       <= 32'd0;
      rInstruction <= 32'd0;
      rNextPC      <= 32'd0;
      rPredict     <= 1'b0;
      rValid       <= 1'b0;
    end else if (iRedirect) begin
      rState  <= REQ;
      rPC     <= iRedirectPC;
      rValid  <= 1'b0;
      rSquash <= squashNext;
    end else if (iHalt && !iStall) begin
      rState  <= HALTED;
      rValid  <= 1'b0;
      rSquash <= squashNext;
    end else begin
      if (deliverNow) begin
        rInstruction <= selInstr;
        rNextPC      <= fallThrough;
        rPredict     <= predTaken;
        rValid       <= 1'b1;
        rPC          <= nextFetchPC;
        rState       <= REQ;
      end else if (!iStall) begin
        rValid <= 1'b0;
      end

      if (bufferNow) begin
        rBufInstr <= iImemData;
        rBufPC    <= rPC;
        rState    <= HOLD;
      end

      if (iImemValid && rSquash) begin
        rSquash <= 1'b0;
      end

      if (rState == fetchState'(2'd3)) begin
        rState <= REQ;
      end
    end
  end

  assign oImemAddr      = rPC;
  assign oImemReq       = (rState == REQ);
  assign oInstruction   = rInstruction;
  assign oNextPC        = rNextPC;
  assign oBranchPredict = rPredict;
  assign oValid         = rValid;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed testbench for instruction_fetch_stage.
// Covers sequential fetch, BHT-driven branch prediction, stall buffering,
// redirect squash, counter saturation, halt/resume and mid-request reset.
module tb_instruction_fetch_stage;

  logic        iClk;
  logic        iRst_n;
  logic [31:0] oImemAddr;
  logic        oImemReq;
  logic [31:0] iImemData;
  logic        iImemValid;
  logic        iStall;
  logic        iHalt;
  logic        iRedirect;
  logic [31:0] iRedirectPC;
  logic        iBhtUpdate;
  logic [31:0] iBhtPC;
  logic        iBhtTaken;
  logic [31:0] oInstruction;
  logic [31:0] oNextPC;
  logic        oBranchPredict;
  logic        oValid;

  int checkCount = 0;
  int failCount  = 0;
  int cycleNum   = 0;

  // Branch at 0x10, offset +3 words: target = 0x14 + 0xC = 0x20.
  localparam logic [31:0] BR_FWD   = 32'h1000_0003;
  // Branch at 0x200, offset -1 word: target = 0x204 - 4 = 0x200.
  localparam logic [31:0] BR_BACK  = 32'h101F_FFFF;
  localparam logic [31:0] W_STALL  = 32'h2000_0014;
  localparam logic [31:0] W_STALE  = 32'h2BAD_0000;
  localparam logic [31:0] W_REDIR  = 32'h2000_0100;
  localparam logic [31:0] W_RESUME = 32'h2000_0040;
  localparam logic [31:0] W_JUNK   = 32'h2DEA_D000;

  instruction_fetch_stage dut (
    .iClk           (iClk),
    .iRst_n         (iRst_n),
    .oImemAddr      (oImemAddr),
    .oImemReq       (oImemReq),
    .iImemData      (iImemData),
    .iImemValid     (iImemValid),
    .iStall         (iStall),
    .iHalt          (iHalt),
    .iRedirect      (iRedirect),
    .iRedirectPC    (iRedirectPC),
    .iBhtUpdate     (iBhtUpdate),
    .iBhtPC         (iBhtPC),
    .iBhtTaken      (iBhtTaken),
    .oInstruction   (oInstruction),
    .oNextPC        (oNextPC),
    .oBranchPredict (oBranchPredict),
    .oValid         (oValid)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply one cycle of memory/stall stimulus; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic v, input logic [31:0] d, input logic st);
    iImemValid = v;
    iImemData  = d;
    iStall     = st;
    @(posedge iClk);
    #1;
    cycleNum++;
    $display("cyc=%0d addr=%h req=%b valid=%b instr=%h next=%h pred=%b",
             cycleNum, oImemAddr, oImemReq, oValid, oInstruction, oNextPC, oBranchPredict);
  endtask

  task automatic bhtPulse(input logic [31:0] pc, input logic taken);
    iBhtUpdate = 1'b1;
    iBhtPC     = pc;
    iBhtTaken  = taken;
  endtask

  initial begin
    iRst_n      = 1'b0;
    iImemData   = 32'd0;
    iImemValid  = 1'b0;
    iStall      = 1'b0;
    iHalt       = 1'b0;
    iRedirect   = 1'b0;
    iRedirectPC = 32'd0;
    iBhtUpdate  = 1'b0;
    iBhtPC      = 32'd0;
    iBhtTaken   = 1'b0;

    // Reset state
    step(1'b0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b0);
    checkVal("rst_valid", 32'(oValid), 32'd0);
    checkVal("rst_addr", oImemAddr, 32'h0);
    checkVal("rst_req", 32'(oImemReq), 32'd1);
    checkVal("rst_instr", oInstruction, 32'd0);
    checkVal("rst_next", oNextPC, 32'd0);
    checkVal("rst_pred", 32'(oBranchPredict), 32'd0);
    iRst_n = 1'b1;

    // Four back-to-back non-branch words
    for (int i = 0; i < 4; i++) begin
      checkVal("seq_addr", oImemAddr, 32'(4 * i));
      step(1'b1, 32'h2000_0000 + 32'(i), 1'b0);
      checkVal("seq_valid", 32'(oValid), 32'd1);
      checkVal("seq_instr", oInstruction, 32'h2000_0000 + 32'(i));
      checkVal("seq_next", oNextPC, 32'(4 * i + 4));
      checkVal("seq_pred", 32'(oBranchPredict), 32'd0);
    end
    checkVal("seq_addr_end", oImemAddr, 32'h10);

    // Train the 0x10 counter 01 -> 10 -> 11, then fetch the branch
    bhtPulse(32'h10, 1'b1);
    step(1'b0, 32'd0, 1'b0);
    checkVal("idle_valid", 32'(oValid), 32'd0);
    step(1'b0, 32'd0, 1'b0);
    iBhtUpdate = 1'b0;
    step(1'b1, BR_FWD, 1'b0);
    checkVal("br_taken_pred", 32'(oBranchPredict), 32'd1);
    checkVal("br_taken_next", oNextPC, 32'h14);
    checkVal("br_taken_addr", oImemAddr, 32'h20);

    // Redirect back to 0x10 with a response in hand (no squash), untrain to 01
    iRedirect   = 1'b1;
    iRedirectPC = 32'h10;
    bhtPulse(32'h10, 1'b0);
    step(1'b1, W_JUNK, 1'b0);
    iRedirect = 1'b0;
    checkVal("redir_nosq_valid", 32'(oValid), 32'd0);
    checkVal("redir_nosq_addr", oImemAddr, 32'h10);
    step(1'b0, 32'd0, 1'b0);
    iBhtUpdate = 1'b0;
    step(1'b1, BR_FWD, 1'b0);
    checkVal("br_nt_valid", 32'(oValid), 32'd1);
    checkVal("br_nt_pred", 32'(oBranchPredict), 32'd0);
    checkVal("br_nt_addr", oImemAddr, 32'h14);

    // Word arrives during a 3-cycle stall
    step(1'b1, W_STALL, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checkVal("stall_instr", oInstruction, BR_FWD);
      checkVal("stall_next", oNextPC, 32'h14);
      checkVal("stall_valid", 32'(oValid), 32'd1);
      checkVal("stall_req", 32'(oImemReq), 32'd0);
      if (i < 2) step(1'b0, 32'd0, 1'b1);
    end
    step(1'b0, 32'd0, 1'b0);
    checkVal("unstall_instr", oInstruction, W_STALL);
    checkVal("unstall_next", oNextPC, 32'h18);
    checkVal("unstall_valid", 32'(oValid), 32'd1);
    checkVal("unstall_addr", oImemAddr, 32'h18);
    step(1'b0, 32'd0, 1'b0);
    checkVal("nodup_valid", 32'(oValid), 32'd0);

    // Redirect with a request outstanding; stale response comes 2 cycles later
    iRedirect   = 1'b1;
    iRedirectPC = 32'h100;
    step(1'b0, 32'd0, 1'b0);
    iRedirect = 1'b0;
    checkVal("redir_addr", oImemAddr, 32'h100);
    step(1'b0, 32'd0, 1'b0);
    step(1'b1, W_STALE, 1'b0);
    checkVal("stale_valid", 32'(oValid), 32'd0);
    checkVal("stale_addr", oImemAddr, 32'h100);
    step(1'b1, W_REDIR, 1'b0);
    checkVal("redir_instr", oInstruction, W_REDIR);
    checkVal("redir_next", oNextPC, 32'h104);
    checkVal("redir_valid", 32'(oValid), 32'd1);

    // Saturation on the 0x200 counter: 4 taken (sat at 11), 1 not-taken -> 10
    iRedirect   = 1'b1;
    iRedirectPC = 32'h200;
    bhtPulse(32'h200, 1'b1);
    step(1'b1, W_JUNK, 1'b0);
    iRedirect = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0);
    bhtPulse(32'h200, 1'b0);
    step(1'b0, 32'd0, 1'b0);
    // Counter 10 read while it is updated to 01: old value predicts taken
    step(1'b1, BR_BACK, 1'b0);
    iBhtUpdate = 1'b0;
    checkVal("sat_pred", 32'(oBranchPredict), 32'd1);
    checkVal("sat_next", oNextPC, 32'h204);
    checkVal("sat_addr", oImemAddr, 32'h200);
    step(1'b1, BR_BACK, 1'b0);
    checkVal("sat_dec_pred", 32'(oBranchPredict), 32'd0);
    checkVal("sat_dec_addr", oImemAddr, 32'h204);

    // Halt with a request outstanding, late response, then redirect to 0x40
    iHalt = 1'b1;
    step(1'b0, 32'd0, 1'b0);
    iHalt = 1'b0;
    checkVal("halt_req", 32'(oImemReq), 32'd0);
    checkVal("halt_valid", 32'(oValid), 32'd0);
    step(1'b1, W_JUNK, 1'b0);
    checkVal("halt_late_valid", 32'(oValid), 32'd0);
    checkVal("halt_late_req", 32'(oImemReq), 32'd0);
    step(1'b0, 32'd0, 1'b0);
    checkVal("halt_stay_req", 32'(oImemReq), 32'd0);
    iRedirect   = 1'b1;
    iRedirectPC = 32'h40;
    step(1'b0, 32'd0, 1'b0);
    iRedirect = 1'b0;
    checkVal("resume_addr", oImemAddr, 32'h40);
    checkVal("resume_req", 32'(oImemReq), 32'd1);
    step(1'b1, W_RESUME, 1'b0);
    checkVal("resume_instr", oInstruction, W_RESUME);
    checkVal("resume_next", oNextPC, 32'h44);

    // Reset while a response is arriving
    iRst_n = 1'b0;
    step(1'b1, W_JUNK, 1'b0);
    iRst_n = 1'b1;
    checkVal("midrst_valid", 32'(oValid), 32'd0);
    checkVal("midrst_addr", oImemAddr, 32'h0);
    checkVal("midrst_instr", oInstruction, 32'd0);
    step(1'b1, 32'h2000_0000, 1'b0);
    checkVal("post_rst_next", oNextPC, 32'h4);
    checkVal("post_rst_valid", 32'(oValid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
Front-end pipeline stage that feeds the instruction decode stage. It holds the PC, issues requests to the instruction memory or cache over a valid handshake, and registers the fetched word with its next-PC and prediction bit. A 2-bit bimodal branch history table (BHT) with branch predecode steers the PC. Redirects from execute, decode stalls and halt are handled here.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
BHT_BITS, 6, log2 of BHT entries (2^BHT_BITS 2-bit counters)
BRANCH_OPCODE, 6'b000100, value of instr[31:26] that marks a conditional branch

Ports:
iClk  input  1  clock
iRst_n  input  1  synchronous active-low reset
oImemAddr  output  32  fetch address (= rPC)
oImemReq  output  1  fetch request, held with a stable address until iImemValid
iImemData  input  32  fetched instruction word
iImemValid  input  1  response valid for the outstanding request
iStall  input  1  decode cannot accept; hold outputs
iHalt  input  1  decoded halt; stop fetching
iRedirect  input  1  mispredict or jump flush from execute
iRedirectPC  input  32  corrected PC
iBhtUpdate  input  1  resolved branch update strobe
iBhtPC  input  32  PC of the resolved branch
iBhtTaken  input  1  resolved direction
oInstruction  output  32  registered instruction to decode
oNextPC  output  32  fetch PC + 4
oBranchPredict  output  1  predicted taken
oValid  output  1  outputs carry a live instruction

Behaviour:
- Reset (iRst_n=0 at posedge): rPC=RESET_PC, state=REQ, oValid=0, oInstruction=0, oNextPC=0, oBranchPredict=0, rSquash=0, every BHT counter=2'b01. Reset has priority over all other inputs, including mid-request. A memory response arriving in the reset cycle is dropped.
- States:
  - REQ: oImemReq=1.
  - HOLD: a word is buffered because of a stall; oImemReq=0.
  - HALTED: oImemReq=0.
- Predecode on the accepted word W at PC P:
  - br = (W[31:26]==BRANCH_OPCODE).
  - Index = P[BHT_BITS+1:2].
  - pred = br & counter[idx][1].
  - target = P+4 + (sext(W[20:0])<<2), all arithmetic mod 2^32.
- REQ, iImemValid=1, rSquash=0, iStall=0:
  - Next edge: oInstruction=W, oNextPC=P+4, oBranchPredict=pred, oValid=1.
  - rPC = pred ? target : P+4. Stay in REQ.
  - Fetch-to-output latency is 1 cycle after iImemValid.
- REQ, iImemValid=1, iStall=1: buffer W and P into HOLD; outputs unchanged.
- HOLD with iStall=0: load outputs from the buffer as above, advance rPC, go to REQ.
- iStall=1: oInstruction, oNextPC, oBranchPredict and oValid hold their values.
- iStall=0 and no word delivered this cycle: oValid=0.
- iRedirect=1, which has priority over stall, halt and delivery:
  - rPC=iRedirectPC, oValid=0, any buffered word discarded, state=REQ.
  - If a request is outstanding and iImemValid=0 in this cycle, set rSquash=1.
- rSquash=1: the next iImemValid response is discarded and rSquash clears. The new address is presented from the cycle after the redirect.
- iHalt=1 with iRedirect=0: go to HALTED once the current output is consumed (iStall=0).
  - An outstanding response is discarded.
  - Only iRedirect or reset leaves HALTED.
- BHT update when iBhtUpdate=1: counter[iBhtPC[BHT_BITS+1:2]] saturating increments if iBhtTaken, otherwise decrements (00..11).
  - A read and an update to the same index in the same cycle: the read sees the old value.
  - The update applies independently of stall, redirect and halt.

Test Plan:
- Reset, memory returns 4 non-branch words with 1-cycle latency → oImemAddr 0,4,8,C; oNextPC 4,8,C,10; oValid=1 each cycle; oBranchPredict=0.
- Branch at PC 0x10 with offset 21'h000003; set counter to 11 via two iBhtUpdate taken pulses → oBranchPredict=1, next oImemAddr=0x20. With counter at 01 → oBranchPredict=0, next address 0x14.
- iStall high for 3 cycles while a word arrives → outputs frozen; the word appears exactly 1 cycle after the stall drops; no word lost or duplicated.
- Redirect to 0x100 while a request is outstanding (iImemValid 2 cycles later) → stale response discarded; next oValid instruction has oNextPC=0x104.
- Saturation: 4 taken updates, then 1 not-taken update on the same PC → counter 11 then 10; prediction stays taken.
- iHalt, then iRedirect to 0x40 → oImemReq=0 while halted; fetching resumes at 0x40. Reset asserted mid-request → oValid=0 and oImemAddr=RESET_PC the next cycle.
